// File: rtl/uvma_mstream_chkr_pkg.sv
// Shared definitions for the Matrix Stream protocol checker.
package uvma_mstream_chkr_pkg;

  // Bit positions inside each channel's 4-bit error flag nibble
  localparam int unsigned ERR_STABLE = 0;
  localparam int unsigned ERR_FRAME  = 1;
  localparam int unsigned ERR_DIM    = 2;
  localparam int unsigned ERR_STALL  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_MTX = 1'b1
  } mtx_state_e;

  // Sampled matrix dimensions are forced into [1, max_v]
  function automatic int unsigned clamp_dim(input int unsigned v, input int unsigned max_v);
    if (v == 0) return 1;
    if (v > max_v) return max_v;
    return v;
  endfunction

endpackage

// File: rtl/uvma_mstream_proto_chkr_ch.sv
// One channel of the Matrix Stream checker: handshake stability, framing,
// dimension and stall rules with sticky flags and counters.
module uvma_mstream_proto_chkr_ch
  import uvma_mstream_chkr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_ROWS      = 64,
  parameter int unsigned MAX_COLS      = 64,
  parameter int unsigned STALL_TIMEOUT = 256,
  parameter int unsigned ERR_CNT_WIDTH = 16,
  localparam int unsigned RW = $clog2(MAX_ROWS) + 1,
  localparam int unsigned CW = $clog2(MAX_COLS) + 1
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic [RW-1:0]            cfg_rows,
  input  logic [CW-1:0]            cfg_cols,
  input  logic                     vld,
  input  logic                     rdy,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     sof,
  input  logic                     eol,
  input  logic                     eof,
  output logic [3:0]               err_flags,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [15:0]              mtx_count,
  output logic                     busy
);

  localparam int unsigned SW = $clog2(STALL_TIMEOUT + 2);

  mtx_state_e state_q, state_d;
  logic [RW-1:0] rows_q, rows_d, row_q, row_d;
  logic [CW-1:0] cols_q, cols_d, col_q, col_d;
  logic          mtx_err_q, mtx_err_d;
  logic          mtx_done;
  logic          mtx_bad;

  logic [RW-1:0] rows_clamp, cur_rows, cur_row;
  logic [CW-1:0] cols_clamp, cur_cols, cur_col;

  logic                  prev_stall_q;
  logic [DATA_WIDTH-1:0] prev_data_q;
  logic                  prev_sof_q, prev_eol_q, prev_eof_q;

  logic [SW-1:0] stall_cnt_q;
  logic          stall_seen_q;
  logic          stall_hit;

  logic [3:0] viol;
  logic       any_viol;
  logic       beat, stalled;

  logic [3:0]               flags_q;
  logic                     pulse_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_q;
  logic [15:0]              mtx_cnt_q;

  assign beat       = vld & rdy;
  assign stalled    = vld & ~rdy;
  assign rows_clamp = RW'(clamp_dim(32'(cfg_rows), MAX_ROWS));
  assign cols_clamp = CW'(clamp_dim(32'(cfg_cols), MAX_COLS));

  // The stall flag comes from the registered run length so it lands one
  // cycle after the edge on which the run reached the limit.
  assign stall_hit = (STALL_TIMEOUT != 0) && (stall_cnt_q == SW'(STALL_TIMEOUT)) && !stall_seen_q;

  // Next-state, position tracking and violation detection
  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    row_d     = row_q;
    col_d     = col_q;
    mtx_err_d = mtx_err_q;
    mtx_done  = 1'b0;
    mtx_bad   = 1'b0;
    viol      = '0;

    // A sof beat starts a fresh matrix regardless of the current state
    cur_rows = sof ? rows_clamp : rows_q;
    cur_cols = sof ? cols_clamp : cols_q;
    cur_row  = sof ? '0 : row_q;
    if (sof || state_q == IDLE) cur_col = CW'(1);
    else                        cur_col = (col_q == '1) ? col_q : col_q + CW'(1);

    viol[ERR_STABLE] = prev_stall_q &&
                       (!vld || data != prev_data_q || sof != prev_sof_q ||
                        eol != prev_eol_q || eof != prev_eof_q);
    viol[ERR_STALL]  = stall_hit;

    if (beat) begin
      if (state_q == IDLE && !sof) begin
        viol[ERR_FRAME] = 1'b1;
      end else begin
        viol[ERR_FRAME] = (state_q == IN_MTX) && sof;
        viol[ERR_DIM]   = (eol != (cur_col == cur_cols)) ||
                          (eof != (eol && (cur_row == cur_rows - RW'(1))));
        mtx_bad = (!sof && mtx_err_q) || (|viol);
        if (eof) begin
          state_d   = IDLE;
          mtx_done  = !mtx_bad;
          mtx_err_d = 1'b0;
        end else begin
          state_d   = IN_MTX;
          rows_d    = cur_rows;
          cols_d    = cur_cols;
          mtx_err_d = mtx_bad;
          if (eol) begin
            col_d = '0;
            row_d = (cur_row == '1) ? cur_row : cur_row + RW'(1);
          end else begin
            col_d = cur_col;
            row_d = cur_row;
          end
        end
      end
    end else if (state_q == IN_MTX) begin
      mtx_err_d = mtx_err_q | (|viol);
    end
  end

  assign any_viol = |viol;

  // Matrix FSM and position registers
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rows_q    <= RW'(1);
      cols_q    <= CW'(1);
      row_q     <= '0;
      col_q     <= '0;
      mtx_err_q <= 1'b0;
    end else if (clr) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      mtx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      row_q     <= row_d;
      col_q     <= col_d;
      mtx_err_q <= mtx_err_d;
    end
  end

  // Previous-cycle beat snapshot for the stability rule
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_stall_q <= 1'b0;
      prev_data_q  <= '0;
      prev_sof_q   <= 1'b0;
      prev_eol_q   <= 1'b0;
      prev_eof_q   <= 1'b0;
    end else begin
      prev_stall_q <= stalled;
      prev_data_q  <= data;
      prev_sof_q   <= sof;
      prev_eol_q   <= eol;
      prev_eof_q   <= eof;
    end
  end

  // Stall run length, held at the limit so the flag fires once per run
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q  <= '0;
      stall_seen_q <= 1'b0;
    end else if (clr || !stalled) begin
      stall_cnt_q  <= '0;
      stall_seen_q <= 1'b0;
    end else begin
      if (stall_cnt_q != SW'(STALL_TIMEOUT)) stall_cnt_q <= stall_cnt_q + SW'(1);
      stall_seen_q <= stall_seen_q | stall_hit;
    end
  end

  // Sticky flags, event pulse and counters; clr wipes history but keeps this cycle's violation
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q   <= '0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
      mtx_cnt_q <= '0;
    end else if (clr) begin
      flags_q   <= viol;
      pulse_q   <= any_viol;
      cnt_q     <= any_viol ? ERR_CNT_WIDTH'(1) : '0;
      mtx_cnt_q <= '0;
    end else begin
      flags_q <= flags_q | viol;
      pulse_q <= any_viol;
      if (any_viol && cnt_q != '1) cnt_q <= cnt_q + ERR_CNT_WIDTH'(1);
      if (mtx_done) mtx_cnt_q <= mtx_cnt_q + 16'd1;
    end
  end

  assign err_flags = flags_q;
  assign err_pulse = pulse_q;
  assign err_count = cnt_q;
  assign mtx_count = mtx_cnt_q;
  assign busy      = (state_q == IN_MTX);

endmodule

// File: rtl/uvma_mstream_proto_chkr.sv
// Multi-channel Matrix Stream protocol checker: one independent checker per channel.
module uvma_mstream_proto_chkr #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_ROWS      = 64,
  parameter int unsigned MAX_COLS      = 64,
  parameter int unsigned STALL_TIMEOUT = 256,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                            sys_clk,
  input  logic                            reset_n,
  input  logic                            clr,
  input  logic [$clog2(MAX_ROWS):0]       cfg_rows,
  input  logic [$clog2(MAX_COLS):0]       cfg_cols,
  input  logic [NUM_CH-1:0]               vld,
  input  logic [NUM_CH-1:0]               rdy,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    data,
  input  logic [NUM_CH-1:0]               sof,
  input  logic [NUM_CH-1:0]               eol,
  input  logic [NUM_CH-1:0]               eof,
  output logic [NUM_CH*4-1:0]             err_flags,
  output logic [NUM_CH-1:0]               err_pulse,
  output logic [NUM_CH*ERR_CNT_WIDTH-1:0] err_count,
  output logic [NUM_CH*16-1:0]            mtx_count,
  output logic [NUM_CH-1:0]               busy
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    uvma_mstream_proto_chkr_ch #(
      .DATA_WIDTH    (DATA_WIDTH),
      .MAX_ROWS      (MAX_ROWS),
      .MAX_COLS      (MAX_COLS),
      .STALL_TIMEOUT (STALL_TIMEOUT),
      .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_ch (
      .sys_clk   (sys_clk),
      .reset_n   (reset_n),
      .clr       (clr),
      .cfg_rows  (cfg_rows),
      .cfg_cols  (cfg_cols),
      .vld       (vld[c]),
      .rdy       (rdy[c]),
      .data      (data[c*DATA_WIDTH +: DATA_WIDTH]),
      .sof       (sof[c]),
      .eol       (eol[c]),
      .eof       (eof[c]),
      .err_flags (err_flags[c*4 +: 4]),
      .err_pulse (err_pulse[c]),
      .err_count (err_count[c*ERR_CNT_WIDTH +: ERR_CNT_WIDTH]),
      .mtx_count (mtx_count[c*16 +: 16]),
      .busy      (busy[c])
    );
  end

endmodule
